dbus_sram_responder: RTL and testbench

Data-bus responder that sits on the slave side of the `dbus_req_t` / `dbus_resp_t` handshake and serves it from an internal 64-bit-wide SRAM array. It accepts one request at a time from a core-side initiator such as the data-memory stage. It performs byte-strobed writes or full-word reads after a configurable latency, and returns bus-aligned data. It is the simulation and standalone memory target for the data path, and a drop-in replacement for the external bus during unit tests.

---
 rtl/dbus_sram_responder.sv | 175 +++++++++++++++++
 tb/tb_dbus_sram_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: single-outstanding data-bus slave backed by a
// 64-bit-wide SRAM array, with byte-strobed writes, full-word reads and a
// fixed request-to-response latency.

package dbus_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy,
  output logic       misaligned
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    COOL
  } state_t;

  state_t             state, state_d;
  logic [3:0]         cnt, cnt_d;

  // Latched request (only the fields the datapath needs after accept)
  logic [IDX_W-1:0]   lat_idx;
  logic [7:0]         lat_strobe;
  logic [63:0]        lat_data;

  // Operand selected for the memory access on the edge entering RESP
  logic [IDX_W-1:0]   op_idx;
  logic [7:0]         op_strobe;
  logic [63:0]        op_data;

  logic               accept;
  logic               enter_resp;
  logic               mis_now;
  logic [7:0]         span;

  logic               addr_ok_q;
  logic               data_ok_q;
  logic               mis_q;
  logic [63:0]        rdata_q;

  logic [63:0]        mem [DEPTH_WORDS];

  // Bits above the word index only alias; fold them so they count as consumed
  logic               unused_addr;
  assign unused_addr = ^dreq.addr;

  // Crossing check: byte offset plus access size past the 8-byte word
  always_comb begin
    span    = 8'd1 << dreq.size;
    mis_now = ({5'd0, dreq.addr[2:0]} + span) > 8'd8;
  end

  // Next-state, counter and memory-operand selection
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    op_idx     = lat_idx;
    op_strobe  = lat_strobe;
    op_data    = lat_data;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          accept = 1'b1;
          cnt_d  = CNT_LOAD;
          if (LATENCY == 1) begin
            // With unit latency the access happens on the accept edge itself,
            // so the operand comes straight from the bus, not the latch.
            state_d    = RESP;
            enter_resp = 1'b1;
            op_idx     = dreq.addr[3 +: IDX_W];
            op_strobe  = dreq.strobe;
            op_data    = dreq.data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_d = COOL;
      COOL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counter, response registers and request latch
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
      mis_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      addr_ok_q <= accept;
      data_ok_q <= enter_resp;
      mis_q     <= accept & mis_now;
      if (enter_resp) begin
        rdata_q <= (op_strobe == 8'd0) ? mem[op_idx] : '0;
      end
      if (accept) begin
        lat_idx    <= dreq.addr[3 +: IDX_W];
        lat_strobe <= dreq.strobe;
        lat_data   <= dreq.data;
      end
    end
  end

  // Byte-strobed array write on the edge entering RESP; reset blocks it
  always_ff @(posedge clk) begin
    if (enter_resp && !reset) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (op_strobe[b]) begin
          mem[op_idx][8*b +: 8] <= op_data[8*b +: 8];
        end
      end
    end
  end

  // Output mapping
  always_comb begin
    dresp.addr_ok = addr_ok_q;
    dresp.data_ok = data_ok_q;
    dresp.data    = rdata_q;
    busy          = (state != IDLE);
    misaligned    = mis_q;
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Bench for dbus_sram_responder: four instances at different latencies,
// a reference memory model and a scoreboard of expected read data.

module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int          N     = 4;
  localparam int unsigned DEPTH = 16;

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      2:       return 5;
      default: return 4;
    endcase
  endfunction

  typedef struct {
    int          dut;
    logic [63:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  req  [N];
  dbus_resp_t resp [N];
  logic       busy [N];
  logic       mis  [N];

  exp_t        sb_q[$];
  logic [63:0] model [N][DEPTH];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    exp_t e;

    dbus_sram_responder #(
      .DEPTH_WORDS(DEPTH),
      .LATENCY    (lat_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .dreq      (req[g]),
      .dresp     (resp[g]),
      .busy      (busy[g]),
      .misaligned(mis[g])
    );

    always @(negedge clk) begin
      if (resp[g].data_ok) begin
        check_eq($sformatf("d%0d sb_depth", g), 64'(sb_q.size()), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check_eq($sformatf("d%0d sb_dut", g), 64'(g), 64'(e.dut));
          check_eq($sformatf("d%0d rdata", g), resp[g].data, e.data);
        end
      end
    end
  end

  // One complete request; checks handshake timing every cycle up to IDLE+1
  task automatic txn(input int d, input logic [31:0] addr, input msize_t size,
                     input logic [7:0] strobe, input logic [63:0] wdata,
                     input logic exp_mis, input int hold);
    int          lat;
    int unsigned idx;
    exp_t        e;
    lat   = lat_of(d);
    idx   = int'(addr[6:3]);
    e.dut = d;
    if (strobe == 8'd0) begin
      e.data = model[d][idx];
    end else begin
      e.data = '0;
      for (int b = 0; b < 8; b++)
        if (strobe[b]) model[d][idx][8*b +: 8] = wdata[8*b +: 8];
    end
    @(negedge clk);
    req[d].valid  = 1'b1;
    req[d].addr   = addr;
    req[d].size   = size;
    req[d].strobe = strobe;
    req[d].data   = wdata;
    sb_q.push_back(e);
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("d%0d addr_ok c%0d", d, k), 64'(resp[d].addr_ok), 64'(k == 1));
      check_eq($sformatf("d%0d data_ok c%0d", d, k), 64'(resp[d].data_ok), 64'(k == lat));
      check_eq($sformatf("d%0d busy c%0d", d, k), 64'(busy[d]), 64'(k <= lat + 1));
      check_eq($sformatf("d%0d misaligned c%0d", d, k), 64'(mis[d]), 64'((k == 1) && exp_mis));
      if (k == lat + 1 + hold) req[d].valid = 1'b0;
    end
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      req[d] = '0;
      for (int w = 0; w < DEPTH; w++) model[d][w] = '0;
    end

    // Reset with valid asserted: reset must win
    reset        = 1'b1;
    req[0].valid = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < N; d++) begin
      check_eq($sformatf("d%0d rst addr_ok", d), 64'(resp[d].addr_ok), 64'd0);
      check_eq($sformatf("d%0d rst data_ok", d), 64'(resp[d].data_ok), 64'd0);
      check_eq($sformatf("d%0d rst data", d), resp[d].data, 64'd0);
      check_eq($sformatf("d%0d rst busy", d), 64'(busy[d]), 64'd0);
      check_eq($sformatf("d%0d rst mis", d), 64'(mis[d]), 64'd0);
    end
    reset        = 1'b0;
    req[0].valid = 1'b0;
    @(negedge clk);
    check_eq("rst_wins addr_ok", 64'(resp[0].addr_ok), 64'd0);
    check_eq("rst_wins busy", 64'(busy[0]), 64'd0);

    // Give every word a known value in each instance
    for (int d = 0; d < N; d++)
      for (int w = 0; w < DEPTH; w++)
        txn(d, 32'h8000_0000 | 32'(w << 3), MSIZE8, 8'hFF,
            {8'(d), 8'(w), 48'h5A5A_0000_A5A5} ^ 64'(w * 32'h0101_0101), 1'b0, 0);

    // Full-word write/read, then a single-byte merge
    txn(0, 32'h8000_0010, MSIZE8, 8'hFF, 64'h1122_3344_5566_7788, 1'b0, 0);
    txn(0, 32'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, 0);
    txn(0, 32'h8000_0013, MSIZE1, 8'h08, 64'h0000_0000_AB00_0000, 1'b0, 0);
    txn(0, 32'h8000_0010, MSIZE8, 8'h00, 64'h0, 1'b0, 0);

    // Unit latency: addr_ok and data_ok coincide
    txn(1, 32'h8000_0028, MSIZE8, 8'hFF, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 0);
    txn(1, 32'h8000_0028, MSIZE8, 8'h00, 64'h0, 1'b0, 0);

    // Latency 5, with valid held through COOL
    txn(2, 32'h8000_0030, MSIZE8, 8'h3C, 64'hFFEE_DDCC_BBAA_9988, 1'b0, 1);
    txn(2, 32'h8000_0030, MSIZE8, 8'h00, 64'h0, 1'b0, 1);

    // Reset during WAIT discards the pending write to word 3
    txn(3, 32'h8000_0018, MSIZE8, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    @(negedge clk);
    req[3].valid  = 1'b1;
    req[3].addr   = 32'h8000_0018;
    req[3].size   = MSIZE8;
    req[3].strobe = 8'hFF;
    req[3].data   = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check_eq("rstwait addr_ok", 64'(resp[3].addr_ok), 64'd1);
    reset        = 1'b1;
    req[3].valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rstwait busy", 64'(busy[3]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("rstwait data_ok %0d", k), 64'(resp[3].data_ok), 64'd0);
      @(negedge clk);
    end
    txn(3, 32'h8000_0018, MSIZE8, 8'h00, 64'h0, 1'b0, 0);

    // Misalignment boundary and address aliasing
    txn(0, 32'h8000_0006, MSIZE4, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b1, 0);
    txn(0, 32'h8000_0004, MSIZE4, 8'hF0, 64'h1357_9BDF_0000_0000, 1'b0, 0);
    txn(0, 32'h8000_0007, MSIZE1, 8'h00, 64'h0, 1'b0, 0);
    txn(0, 32'h8000_0007, MSIZE2, 8'h00, 64'h0, 1'b1, 0);
    txn(0, 32'h8000_0008 + 32'(8 * DEPTH), MSIZE8, 8'hFF, 64'hA1A2_A3A4_A5A6_A7A8, 1'b0, 0);
    txn(0, 32'h8000_0008, MSIZE8, 8'h00, 64'h0, 1'b0, 0);

    // Random aligned traffic against the model
    for (int i = 0; i < 24; i++) begin
      int unsigned w;
      logic [7:0]  s;
      w = $urandom_range(0, DEPTH - 1);
      s = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      txn(i % N, 32'h8000_0000 | 32'(w << 3), MSIZE8, s, {$urandom, $urandom}, 1'b0, 0);
    end

    repeat (2) @(negedge clk);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
